// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised valid/ready pipeline stage register with flush and stall counter
// Optional skid buffer (registered in_ready) enabled by defining PIPE_STAGE_REG_SKID_EN.
module pipe_stage_reg #(
  parameter int unsigned        DATA_W      = 64,
  parameter logic [DATA_W-1:0]  RESET_VAL   = '0,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL  = '0,
  parameter int unsigned        STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              in_xfer;
  logic              out_xfer;
  logic [DATA_W-1:0] main_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (in_xfer) state_next = S_FULL;
`ifdef PIPE_STAGE_REG_SKID_EN
        S_FULL: begin
          if (in_xfer && !out_ready) begin
            state_next = S_SKID;
          end else if (!in_xfer && out_ready) begin
            state_next = S_EMPTY;
          end
        end
        S_SKID: if (out_ready) state_next = S_FULL;
`else
        S_FULL: if (out_xfer && !in_xfer) state_next = S_EMPTY;
`endif
        default: state_next = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state != S_EMPTY);
`ifdef PIPE_STAGE_REG_SKID_EN
    // Decoded purely from the state flop: no combinational path from out_ready.
    in_ready  = (state != S_SKID);
`else
    in_ready  = !out_valid || out_ready;
`endif
    in_xfer   = in_valid && in_ready;
    out_xfer  = out_valid && out_ready;
  end

`ifdef PIPE_STAGE_REG_SKID_EN
  logic [DATA_W-1:0] skid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_q <= RESET_VAL;
      skid_q <= '0;
    end else if (flush) begin
      main_q <= BUBBLE_VAL;
    end else if (state == S_SKID) begin
      if (out_ready) main_q <= skid_q;
    end else if (in_xfer) begin
      // A beat arriving while the main entry is stalled parks in the skid slot.
      if (state == S_FULL && !out_ready) begin
        skid_q <= in_data;
      end else begin
        main_q <= in_data;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      main_q <= RESET_VAL;
    end else if (flush) begin
      main_q <= BUBBLE_VAL;
    end else if (in_xfer) begin
      main_q <= in_data;
    end
  end
`endif

  assign out_data = main_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] BV = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        flush;
  logic [15:0] stall_cnt;

  logic        in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [2:0]  stall_cnt3;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(32), .RESET_VAL(RV), .BUBBLE_VAL(BV), .STALL_CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(
    .DATA_W(8), .RESET_VAL(8'h00), .BUBBLE_VAL(8'h13), .STALL_CNT_W(3)
  ) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data[7:0]), .out_valid(out_valid3), .out_ready(out_ready),
    .out_data(out_data3), .flush(flush), .stall_cnt(stall_cnt3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset held with a beat offered
    reset = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1; flush = 1'b0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, RV);
    check("rst_stall_cnt", stall_cnt, 0);
    reset = 1'b1; in_valid = 1'b0; #1;
    check("rst_in_ready", in_ready, 1);

    // 2: streaming at full rate
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = i;
      #1;
      check("stream_in_ready", in_ready, 1);
      tick();
      check("stream_out_valid", out_valid, 1);
      check("stream_out_data", out_data, i);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", out_valid, 0);

    // 3: stall with a second beat pending
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    check("stall_first", out_data, 32'hA);
    out_ready = 1'b0; in_data = 32'hB; #1;
`ifdef PIPE_STAGE_REG_SKID_EN
    check("stall_in_ready_pre", in_ready, 1);
`else
    check("stall_in_ready_pre", in_ready, 0);
`endif
    for (int i = 0; i < 4; i++) tick();
    check("stall_hold_data", out_data, 32'hA);
    check("stall_hold_valid", out_valid, 1);
    check("stall_in_ready", in_ready, 0);
    check("stall_cnt4", stall_cnt, 4);
    out_ready = 1'b1;
    tick();
    check("stall_second", out_data, 32'hB);
    check("stall_second_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    check("stall_no_dup", out_valid, 0);
    check("stall_cnt_keep", stall_cnt, 4);

    // 4: flush while full (skid entry occupied in skid builds)
    in_valid = 1'b1; in_data = 32'hC;
    tick();
    out_ready = 1'b0; in_data = 32'hD;
    tick();
    check("pre_flush_data", out_data, 32'hC);
    flush = 1'b1; in_data = 32'hE;
    tick();
    check("flush_valid", out_valid, 0);
    check("flush_data", out_data, BV);
    check("flush_in_ready", in_ready, 1);
    check("flush_stall_cnt", stall_cnt, 6);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("flush_no_leak_valid", out_valid, 0);
    check("flush_no_leak_data", out_data, BV);

    // 5: saturation of a 3-bit stall counter
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("sat_rst", stall_cnt3, 0);
    in_valid = 1'b1; in_data = 32'h5A;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("sat_cnt3", stall_cnt3, 7);
    check("sat_cnt16", stall_cnt, 10);
    check("sat_data3", out_data3, 8'h5A);
    tick();
    check("sat_hold", stall_cnt3, 7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("sat_after_flush", stall_cnt3, 7);
    check("sat_after_flush16", stall_cnt, 12);
    check("sat_flush_data3", out_data3, 8'h13);
    reset = 1'b0;
    tick();
    check("sat_cleared", stall_cnt3, 0);
    reset = 1'b1;

    // 6: reset and flush together while stalled (SKID state in skid builds)
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h21;
    tick();
    out_ready = 1'b0; in_data = 32'h22;
    tick();
    check("pre_rst_cnt", stall_cnt, 1);
    reset = 1'b0; flush = 1'b1; in_data = 32'h23;
    tick();
    check("rf_valid", out_valid, 0);
    check("rf_data", out_data, RV);
    check("rf_stall_cnt", stall_cnt, 0);
    check("rf_in_ready", in_ready, 1);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("rf_skid_empty", out_valid, 0);
    check("rf_data_hold", out_data, RV);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
